// File: rtl/serial_regfile.sv
`default_nettype none
// ============================================================================
// Module      : serial_regfile
// Description : Bit-serial register file. A start request rotates every
//               register through XLEN/DIGIT shift cycles, MSB digit first.
//               Two read ports expose the outgoing MSB digit. One serial
//               write port replaces the digit being recirculated. An
//               idle-only parallel port loads or inspects whole registers.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_regfile #(
  parameter int XLEN     = 32,
  parameter int DIGIT    = 2,
  parameter int NREGS    = 16,
  parameter int ZERO_REG = 1,
  localparam int N       = XLEN / DIGIT,
  localparam int IDXW    = (N > 1) ? $clog2(N) : 1,
  localparam int SELW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDXW-1:0]   digit_idx,
  input  logic [SELW-1:0]   r_sel1,
  input  logic [SELW-1:0]   r_sel2,
  output logic [DIGIT-1:0]  r_digit1,
  output logic [DIGIT-1:0]  r_digit2,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [DIGIT-1:0]  wr_digit,
  input  logic              pld_en,
  input  logic [SELW-1:0]   pld_sel,
  input  logic [XLEN-1:0]   pld_data,
  input  logic [SELW-1:0]   dbg_sel,
  output logic [XLEN-1:0]   dbg_value
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ROTATE = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(N - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [DIGIT-1:0]  w_ins;

  // Next-state: idle-side parallel load / launch, rotate-side shift with digit insert
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    w_ins   = '0;
    case (state_q)
      ST_IDLE: begin
        // The load lands at this edge, so a simultaneous start rotates the new value
        if (pld_en) begin
          regs_d[pld_sel] = pld_data;
        end
        if (start) begin
          state_d = ST_ROTATE;
          idx_d   = '0;
        end
      end
      ST_ROTATE: begin
        for (int r = 0; r < NREGS; r++) begin
          w_ins = regs_q[r][XLEN-1 -: DIGIT];
          if (wr_en && (wr_sel == SELW'(r))) begin
            w_ins = wr_digit;
          end
          regs_d[r] = (regs_q[r] << DIGIT) | XLEN'(w_ins);
        end
        if (idx_q == C_LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    // Hard-wired zero register: storage never leaves 0, so reads need no masking
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
    end
  end

  // State, digit counter, done pulse and register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  assign busy      = (state_q == ST_ROTATE);
  assign done      = done_q;
  assign digit_idx = idx_q;
  assign r_digit1  = regs_q[r_sel1][XLEN-1 -: DIGIT];
  assign r_digit2  = regs_q[r_sel2][XLEN-1 -: DIGIT];
  assign dbg_value = regs_q[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_serial_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_regfile
// Description : Self-checking bench for serial_regfile (2-bit and 4-bit
//               digit configurations) against a whole-word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, wr_en = 1'b0, pld_en = 1'b0;
  logic [3:0]  r_sel1 = '0, r_sel2 = '0, wr_sel = '0, pld_sel = '0, dbg_sel = '0;
  logic [1:0]  wr_digit = '0;
  logic [31:0] pld_data = '0;
  logic        busy, done;
  logic [3:0]  digit_idx;
  logic [1:0]  r_digit1, r_digit2;
  logic [31:0] dbg_value;

  logic        b_start = 1'b0, b_wr_en = 1'b0, b_pld_en = 1'b0;
  logic [2:0]  b_r_sel1 = '0, b_r_sel2 = '0, b_wr_sel = '0, b_pld_sel = '0, b_dbg_sel = '0;
  logic [3:0]  b_wr_digit = '0;
  logic [31:0] b_pld_data = '0;
  logic        b_busy, b_done;
  logic [2:0]  b_digit_idx;
  logic [3:0]  b_r_digit1, b_r_digit2;
  logic [31:0] b_dbg_value;

  // Reference model: whole-word register contents
  logic [31:0] m  [16];
  logic [31:0] m4 [8];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_regfile dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .digit_idx(digit_idx),
    .r_sel1(r_sel1), .r_sel2(r_sel2), .r_digit1(r_digit1), .r_digit2(r_digit2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_digit(wr_digit),
    .pld_en(pld_en), .pld_sel(pld_sel), .pld_data(pld_data),
    .dbg_sel(dbg_sel), .dbg_value(dbg_value)
  );

  serial_regfile #(.XLEN(32), .DIGIT(4), .NREGS(8), .ZERO_REG(1)) dut4 (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .digit_idx(b_digit_idx),
    .r_sel1(b_r_sel1), .r_sel2(b_r_sel2), .r_digit1(b_r_digit1), .r_digit2(b_r_digit2),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_digit(b_wr_digit),
    .pld_en(b_pld_en), .pld_sel(b_pld_sel), .pld_data(b_pld_data),
    .dbg_sel(b_dbg_sel), .dbg_value(b_dbg_value)
  );

  task automatic pld_idle(input logic [3:0] sel, input logic [31:0] data);
    pld_en = 1'b1; pld_sel = sel; pld_data = data;
    @(posedge clk); #1;
    pld_en = 1'b0;
    if (sel != 4'd0) m[sel] = data;
  endtask

  // One full rotation on the 2-bit instance with optional serial write, optional
  // load coincident with start, ignored start pulses and an ignored mid-rotation load
  task automatic do_rotation(input bit wr_on, input logic [3:0] wsel, input logic [31:0] wval,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input bit load_on, input logic [3:0] lsel, input logic [31:0] ldata,
                             input bit mid_start);
    logic [31:0] orig [16];
    r_sel1 = s1; r_sel2 = s2; start = 1'b1;
    if (load_on) begin pld_en = 1'b1; pld_sel = lsel; pld_data = ldata; end
    @(posedge clk); #1;
    start = 1'b0; pld_en = 1'b0;
    if (load_on && lsel != 4'd0) m[lsel] = ldata;
    orig = m;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rot_busy i=%0d got %b exp 1", i, busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rot_done_early i=%0d got %b exp 0", i, done); end
      n_cmp++; if (digit_idx !== 4'(i)) begin n_err++; $display("FAIL rot_idx got %0d exp %0d", digit_idx, i); end
      n_cmp++; if (r_digit1 !== orig[s1][31-2*i -: 2]) begin n_err++; $display("FAIL rot_rd1 i=%0d sel=%0d got %0d exp %0d", i, s1, r_digit1, orig[s1][31-2*i -: 2]); end
      n_cmp++; if (r_digit2 !== orig[s2][31-2*i -: 2]) begin n_err++; $display("FAIL rot_rd2 i=%0d sel=%0d got %0d exp %0d", i, s2, r_digit2, orig[s2][31-2*i -: 2]); end
      wr_en = wr_on; wr_sel = wsel; wr_digit = wval[31-2*i -: 2];
      start = (mid_start && (i == 5 || i == 15)) ? 1'b1 : 1'b0;
      if (i == 3) begin pld_en = 1'b1; pld_sel = s1; pld_data = $urandom; end
      else pld_en = 1'b0;
      @(posedge clk); #1;
    end
    wr_en = 1'b0; start = 1'b0; pld_en = 1'b0;
    if (wr_on && wsel != 4'd0) m[wsel] = wval;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL end_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL end_done got %b exp 1", done); end
    n_cmp++; if (digit_idx !== 4'd0) begin n_err++; $display("FAIL end_idx got %0d exp 0", digit_idx); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post_done got done=%b busy=%b exp 0/0", done, busy); end
    for (int r = 0; r < 16; r++) begin
      dbg_sel = 4'(r); #1;
      n_cmp++; if (dbg_value !== m[r]) begin n_err++; $display("FAIL rot_dbg r%0d got %h exp %h", r, dbg_value, m[r]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 16; r++) m[r] = '0;
    for (int r = 0; r < 8; r++) m4[r] = '0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || digit_idx !== 4'd0) begin n_err++; $display("FAIL reset_ctrl got busy=%b done=%b idx=%0d exp 0/0/0", busy, done, digit_idx); end
    for (int r = 0; r < 16; r++) begin
      r_sel1 = 4'(r); r_sel2 = 4'(15 - r); dbg_sel = 4'(r); #1;
      n_cmp++; if (r_digit1 !== 2'd0 || r_digit2 !== 2'd0) begin n_err++; $display("FAIL reset_rd r%0d got %0d/%0d exp 0/0", r, r_digit1, r_digit2); end
      n_cmp++; if (dbg_value !== 32'd0) begin n_err++; $display("FAIL reset_dbg r%0d got %h exp 0", r, dbg_value); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_rotate();
    pld_idle(4'd3, 32'hDEADBEEF);
    do_rotation(1'b0, 4'd0, 32'd0, 4'd3, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_serial_write();
    pld_idle(4'd5, 32'hA5A5_0F0F);
    do_rotation(1'b1, 4'd5, 32'h12345678, 4'd3, 4'd5, 1'b0, 4'd0, 32'd0, 1'b1);
  endtask

  task automatic test_zero_reg();
    pld_idle(4'd0, 32'hFFFFFFFF);
    do_rotation(1'b1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic test_idle_write_ignored();
    wr_en = 1'b1; wr_sel = 4'd3; wr_digit = 2'd0;
    repeat (4) @(posedge clk);
    #1 wr_en = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_wr_busy got %b exp 0", busy); end
    dbg_sel = 4'd3; #1;
    n_cmp++; if (dbg_value !== m[3]) begin n_err++; $display("FAIL idle_wr_dbg got %h exp %h", dbg_value, m[3]); end
  endtask

  task automatic test_start_with_load();
    do_rotation(1'b0, 4'd0, 32'd0, 4'd9, 4'd3, 1'b1, 4'd9, $urandom, 1'b0);
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_end got done=%b busy=%b exp 1/0", done, busy); end
    @(posedge clk); #1 start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || digit_idx !== 4'd0 || done !== 1'b0) begin n_err++; $display("FAIL b2b_restart got busy=%b idx=%0d done=%b exp 1/0/0", busy, digit_idx, done); end
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1 || digit_idx !== 4'd15) begin n_err++; $display("FAIL b2b_last got busy=%b idx=%0d exp 1/15", busy, digit_idx); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_done2 got done=%b busy=%b exp 1/0", done, busy); end
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      dbg_sel = 4'(r); #1;
      n_cmp++; if (dbg_value !== m[r]) begin n_err++; $display("FAIL b2b_dbg r%0d got %h exp %h", r, dbg_value, m[r]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      pld_idle(4'($urandom_range(15)), $urandom);
      pld_idle(4'($urandom_range(15)), $urandom);
      do_rotation(1'($urandom), 4'($urandom_range(15)), $urandom,
                  4'($urandom_range(15)), 4'($urandom_range(15)),
                  1'($urandom), 4'($urandom_range(15)), $urandom, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    pld_idle(4'd7, 32'h0BAD_CAFE);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < 16; r++) m[r] = '0;
    for (int r = 0; r < 8; r++) m4[r] = '0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || digit_idx !== 4'd0) begin n_err++; $display("FAIL rstmid_ctrl got busy=%b done=%b idx=%0d exp 0/0/0", busy, done, digit_idx); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_nodone got %b exp 0", done); end
    for (int r = 0; r < 16; r++) begin
      dbg_sel = 4'(r); #1;
      n_cmp++; if (dbg_value !== m[r]) begin n_err++; $display("FAIL rstmid_dbg r%0d got %h exp %h", r, dbg_value, m[r]); end
    end
  endtask

  task automatic test_digit4();
    logic [31:0] orig [8];
    logic [31:0] wval;
    wval = $urandom;
    b_pld_en = 1'b1; b_pld_sel = 3'd7; b_pld_data = 32'hCAFEF00D;
    @(posedge clk); #1 b_pld_en = 1'b0;
    m4[7] = 32'hCAFEF00D;
    b_r_sel1 = 3'd7; b_r_sel2 = 3'd2; b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    orig = m4;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (b_busy !== 1'b1 || b_digit_idx !== 3'(i)) begin n_err++; $display("FAIL d4_ctrl i=%0d got busy=%b idx=%0d exp 1/%0d", i, b_busy, b_digit_idx, i); end
      n_cmp++; if (b_r_digit1 !== orig[7][31-4*i -: 4]) begin n_err++; $display("FAIL d4_rd1 i=%0d got %h exp %h", i, b_r_digit1, orig[7][31-4*i -: 4]); end
      n_cmp++; if (b_r_digit2 !== orig[2][31-4*i -: 4]) begin n_err++; $display("FAIL d4_rd2 i=%0d got %h exp %h", i, b_r_digit2, orig[2][31-4*i -: 4]); end
      b_wr_en = 1'b1; b_wr_sel = 3'd2; b_wr_digit = wval[31-4*i -: 4];
      @(posedge clk); #1;
    end
    b_wr_en = 1'b0;
    m4[2] = wval;
    n_cmp++; if (b_busy !== 1'b0 || b_done !== 1'b1) begin n_err++; $display("FAIL d4_end got busy=%b done=%b exp 0/1", b_busy, b_done); end
    @(posedge clk); #1;
    n_cmp++; if (b_done !== 1'b0) begin n_err++; $display("FAIL d4_post_done got %b exp 0", b_done); end
    for (int r = 0; r < 8; r++) begin
      b_dbg_sel = 3'(r); #1;
      n_cmp++; if (b_dbg_value !== m4[r]) begin n_err++; $display("FAIL d4_dbg r%0d got %h exp %h", r, b_dbg_value, m4[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_rotate();
    test_serial_write();
    test_zero_reg();
    test_idle_write_ignored();
    test_start_with_load();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_digit4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
